vluint7_decoder: RTL and testbench

// - Decodes one unsigned LEB128-style variable-length integer (VLUINT7) from
//   an internal byte memory, starting at a caller-supplied address.
// - Each byte carries 7 payload bits, least-significant group first.
//   Bit 7 = 1 means another byte follows; bit 7 = 0 marks the last byte.
// - Returns the zero-extended value and the address of the next encoded

---
 rtl/vluint7_decoder.sv | 118 +++++++++++
 tb/tb_vluint7_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vluint7_decoder.sv
// Decodes one unsigned LEB128-style (VLUINT7) integer from a fixed internal byte ROM.
// Returns the zero-extended value and the address of the next encoded integer.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module vluint7_decoder #(
    parameter int MEM_ADDR_WIDTH = `MEM_ADDR_WIDTH,
    parameter int WORD_WIDTH     = `WORD_WIDTH,
    parameter int MAX_BYTES      = (WORD_WIDTH + 6) / 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MEM_ADDR_WIDTH-1:0] addr,
    input  logic                      beg,
    output logic [WORD_WIDTH-1:0]     data,
    output logic [MEM_ADDR_WIDTH-1:0] addr_out,
    output logic                      rd
);

    localparam int SHIFT_W = $clog2(7 * MAX_BYTES + 1);
    localparam int CNT_W   = $clog2(MAX_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_r;
    logic [MEM_ADDR_WIDTH-1:0] ptr_r;
    logic [WORD_WIDTH-1:0]     acc_r;
    logic [SHIFT_W-1:0]        shift_r;
    logic [CNT_W-1:0]          cnt_r;

    logic [7:0]                byte_s;
    logic [WORD_WIDTH-1:0]     acc_next_s;
    logic                      last_s;

    // Fixed ROM contents; every location not listed reads as zero.
    function automatic logic [7:0] rom_read(input logic [MEM_ADDR_WIDTH-1:0] a);
        logic [7:0] b;
        case (a)
            MEM_ADDR_WIDTH'(0): b = 8'hEE;
            MEM_ADDR_WIDTH'(1): b = 8'h96;
            MEM_ADDR_WIDTH'(2): b = 8'h01;
            MEM_ADDR_WIDTH'(3): b = 8'h58;
            MEM_ADDR_WIDTH'(4): b = 8'h9D;
            MEM_ADDR_WIDTH'(5): b = 8'hD6;
            MEM_ADDR_WIDTH'(6): b = 8'h06;
            default:            b = 8'h00;
        endcase
        return b;
    endfunction

    // Current byte, accumulator update and end-of-integer detection.
    always_comb begin
        byte_s     = rom_read(ptr_r);
        acc_next_s = acc_r | (WORD_WIDTH'(byte_s[6:0]) << shift_r);
        if (!byte_s[7] || (cnt_r + CNT_W'(1) == CNT_W'(MAX_BYTES))) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Decoder FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            data     <= {WORD_WIDTH{1'b0}};
            addr_out <= {MEM_ADDR_WIDTH{1'b0}};
            rd       <= 1'b0;
            ptr_r    <= {MEM_ADDR_WIDTH{1'b0}};
            acc_r    <= {WORD_WIDTH{1'b0}};
            shift_r  <= {SHIFT_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (beg) begin
                        ptr_r   <= addr;
                        acc_r   <= {WORD_WIDTH{1'b0}};
                        shift_r <= {SHIFT_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        rd      <= 1'b0;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    acc_r   <= acc_next_s;
                    ptr_r   <= ptr_r + MEM_ADDR_WIDTH'(1);
                    shift_r <= shift_r + SHIFT_W'(7);
                    cnt_r   <= cnt_r + CNT_W'(1);
                    // A full-length integer terminates even if its last byte says "more".
                    if (last_s) begin
                        data     <= acc_next_s;
                        addr_out <= ptr_r + MEM_ADDR_WIDTH'(1);
                        rd       <= 1'b1;
                        state_r  <= DONE;
                    end
                end
                DONE: begin
                    if (!beg) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vluint7_decoder.sv
// Randomized self-checking bench for vluint7_decoder against an arithmetic VLUINT7 model.
`timescale 1ns/1ps

module tb_vluint7_decoder;

    localparam int AW    = 8;
    localparam int WW    = 32;
    localparam int MAXB  = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic [AW-1:0] addr;
    logic          beg;
    logic [WW-1:0] data;
    logic [AW-1:0] addr_out;
    logic          rd;

    int checks;
    int failures;
    int mem_m [DEPTH];

    vluint7_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .beg      (beg),
        .data     (data),
        .addr_out (addr_out),
        .rd       (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: value = sum of 7-bit groups times 128^i, stop at a clear top bit or MAXB bytes.
    task automatic model(input int a, output longint val, output int nxt, output int nb);
        longint acc;
        longint weight;
        int     p;
        int     b;
        acc    = 0;
        weight = 1;
        p      = a;
        nb     = 0;
        for (int i = 0; i < MAXB; i++) begin
            b      = mem_m[p];
            acc    = acc + (b % 128) * weight;
            weight = weight * 128;
            p      = (p + 1) % DEPTH;
            nb++;
            if (b < 128) break;
        end
        val = acc % (longint'(1) << WW);
        nxt = p;
    endtask

    task automatic run_decode(input int a, input int hold);
        longint ev;
        int     en;
        int     nb;
        int     lat;
        int     drops;
        model(a, ev, en, nb);
        @(negedge clk);
        addr = AW'(a);
        beg  = 1'b1;
        @(posedge clk);
        #1;
        check_val("rd_clear_on_start", rd, 0);
        lat = 0;
        while (!rd && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("latency", lat, nb);
        check_val("data", data, ev);
        check_val("addr_out", addr_out, en);
        drops = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (!rd) drops++;
        end
        check_val("no_redecode", drops, 0);
        check_val("hold_data", data, ev);
        @(negedge clk);
        beg = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("idle_rd", rd, 1);
        check_val("idle_data", data, ev);
        check_val("idle_addr_out", addr_out, en);
    endtask

    initial begin
        longint ev;
        int     en;
        int     nb;
        int     sel;
        int     a;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
        mem_m[0] = 'hEE; mem_m[1] = 'h96; mem_m[2] = 'h01; mem_m[3] = 'h58;
        mem_m[4] = 'h9D; mem_m[5] = 'hD6; mem_m[6] = 'h06;

        // Sanity of the model against the known worked values.
        model(0, ev, en, nb);
        check_val("model_0", ev, 19310);
        model(4, ev, en, nb);
        check_val("model_4", ev, 109341);

        reset = 1'b1;
        beg   = 1'b0;
        addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_rd", rd, 0);
        check_val("reset_data", data, 0);
        check_val("reset_addr_out", addr_out, 0);
        @(negedge clk);
        reset = 1'b0;

        run_decode(0, 10);
        run_decode(3, 10);
        run_decode(4, 100);
        run_decode(7, 3);
        run_decode(DEPTH - 1, 3);

        // Reset in the middle of a decode aborts it and clears the result.
        run_decode(4, 2);
        @(negedge clk);
        addr = '0;
        beg  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        beg   = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort_rd", rd, 0);
        check_val("abort_data", data, 0);
        check_val("abort_addr_out", addr_out, 0);
        @(negedge clk);
        reset = 1'b0;
        run_decode(0, 3);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      a = $urandom_range(0, 8);
            else if (sel == 1) a = $urandom_range(DEPTH - 6, DEPTH - 1);
            else if (sel == 2) a = $urandom_range(0, 2);
            else               a = $urandom_range(0, DEPTH - 1);
            run_decode(a, $urandom_range(0, 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
